cpu_seq_ctrl: RTL and testbench
===============================

Name: cpu_seq_ctrl

Overview:
Multi-cycle fetch/decode/execute sequencer for the 8-bit register-file + ALU datapath. It fetches 20-bit instructions from an external synchronous instruction memory and drives the datapath control inputs (write enable/address, read addresses, ALU select, immediate, operand-B mux). It tracks a program counter and a carry flag for conditional branching. It sits between the instruction ROM and the datapath and provides a start/done handshake to the testbench or host.

Parameters:
WIDTH, 8, datapath data width; immediate field width
REG_COUNT, 8, number of datapath registers; RA_W = $clog2(REG_COUNT) = 3
PC_W, 8, program counter / imem address width
INSTR_W, 20, instruction width (fixed encoding below, requires WIDTH<=8, RA_W<=3)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin execution at address 0; sampled only in IDLE
imem_en  out  1  instruction memory read strobe
imem_addr  out  PC_W  instruction address (= pc)
imem_data  in  INSTR_W  instruction, valid 1 cycle after imem_en
dp_write_en  out  1  datapath register write enable
dp_write_addr  out  RA_W  destination register
dp_read_addr1  out  RA_W  source A register
dp_read_addr2  out  RA_W  source B register
dp_alu_sel  out  3  ALU operation select
dp_mux_sel  out  1  0: operand B = register, 1: immediate
dp_immediate  out  WIDTH  immediate operand
dp_carry_out  in  1  ALU carry of current operation
busy  out  1  high from leaving IDLE until done
done  out  1  single-cycle pulse on HALT

Behaviour:
- Encoding: [19:18] type (00 ALU-reg, 01 ALU-imm, 10 BRC, 11 HALT); [17:15] alu_sel; [14:12] rd; [11:9] rs1; [7:0] imm; rs2 = [2:0] for ALU-reg; [8] ignored.
- States: IDLE, FETCH, WAIT, EXEC.
- IDLE: start=1 -> FETCH, with pc<=0 and carry_flag<=0. busy=0.
- FETCH: imem_en=1, imem_addr=pc -> WAIT.
- WAIT: ir <= imem_data -> EXEC.
- EXEC: datapath controls decoded combinationally from ir. Exactly one cycle.
  - ALU-reg: write_en=1, mux_sel=0, read_addr1=rs1, read_addr2=rs2, write_addr=rd. carry_flag<=dp_carry_out. pc<=pc+1 -> FETCH.
  - ALU-imm: same as ALU-reg but mux_sel=1 and dp_immediate=imm.
  - BRC: write_en=0. If carry_flag=1, pc<=imm[PC_W-1:0], else pc<=pc+1. carry_flag unchanged -> FETCH.
  - HALT: write_en=0, done=1 for this cycle -> IDLE. pc is held.
- Timing: 3 cycles per instruction. The register write commits at the EXEC clock edge.
- Outside EXEC, all dp_* outputs = 0. imem_en=0 except in FETCH.
- pc+1 wraps from 2^PC_W-1 to 0 with no error.
- busy = (state != IDLE). done is asserted only in the HALT EXEC cycle.
- start while busy: ignored. start in the same cycle as rst: rst wins.
- Reset values: state=IDLE, pc=0, ir=0, carry_flag=0; all outputs 0.
- Reset mid-program: returns to IDLE next edge; any in-flight EXEC write is suppressed if rst is high in that cycle (write_en gated by !rst).

Decomposition:
- Package cpu_ctrl_pkg:
  - instruction type constants (TYPE_ALU_R, TYPE_ALU_I, TYPE_BRC, TYPE_HALT)
  - field bit-position localparams
  - state encoding (ST_IDLE, ST_FETCH, ST_WAIT, ST_EXEC)
- Sub-module cpu_instr_decode (combinational): ir and exec-valid in -> dp_* controls, is_branch, is_halt, updates_carry.
- FSM, pc, ir and carry_flag stay in cpu_seq_ctrl.

Test Plan:
- rst, then start with ROM = {ALU-imm alu_sel=ADD rd=1 rs1=0 imm=0x05, HALT} -> FETCH/WAIT/EXEC sequence; at EXEC dp_write_en=1, write_addr=1, mux_sel=1, immediate=0x05; done pulses at cycle 6 after start; busy high cycles 1-6.
- ALU-reg rd=3 rs1=1 rs2=2 -> read_addr1=1, read_addr2=2, write_addr=3, mux_sel=0 for exactly one cycle; dp_* = 0 in FETCH/WAIT.
- Carry loop: ADD r1=0xFF+imm 0x01 (dp_carry_out=1), then BRC imm=0x10 -> next imem_addr=0x10. Repeat with carry=0 -> imem_addr=pc+1.
- PC wrap: NOP-like ALU ops at 0xFF -> next fetch address 0x00.
- start pulsed while busy -> no restart, pc unaffected. After HALT, a new start -> fetch from 0x00 with carry_flag=0.
- rst asserted during EXEC of an ALU op -> dp_write_en=0 that cycle; next cycle IDLE, busy=0, pc=0, no done pulse.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the fetch/decode/execute sequencer.
//   - instruction type codes held in ir[19:18]
//   - bit positions of every instruction field
//   - sequencer state encoding
package cpu_ctrl_pkg;

  localparam logic [1:0] TYPE_ALU_R = 2'b00;
  localparam logic [1:0] TYPE_ALU_I = 2'b01;
  localparam logic [1:0] TYPE_BRC   = 2'b10;
  localparam logic [1:0] TYPE_HALT  = 2'b11;

  localparam int TYPE_MSB = 19;
  localparam int TYPE_LSB = 18;
  localparam int ALU_MSB  = 17;
  localparam int ALU_LSB  = 15;
  localparam int RD_LSB   = 12;
  localparam int RS1_LSB  = 9;
  localparam int IGN_BIT  = 8;
  localparam int IMM_LSB  = 0;
  localparam int RS2_LSB  = 0;

  localparam int ALU_SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_EXEC  = 2'd3
  } state_t;

endpackage

// File: rtl/cpu_instr_decode.sv
// Combinational instruction decoder.
// Ports:
//   ir            in   latched instruction word
//   exec_valid    in   high only in the EXEC state; all outputs are 0 otherwise
//   dp_*          out  datapath controls for the current instruction
//   is_branch     out  instruction is a conditional branch on carry
//   is_halt       out  instruction is HALT
//   updates_carry out  instruction is an ALU op whose carry must be captured
module cpu_instr_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int RA_W    = 3,
  parameter int INSTR_W = 20
) (
  input  logic [INSTR_W-1:0]   ir,
  input  logic                 exec_valid,
  output logic                 dp_write_en,
  output logic [RA_W-1:0]      dp_write_addr,
  output logic [RA_W-1:0]      dp_read_addr1,
  output logic [RA_W-1:0]      dp_read_addr2,
  output logic [ALU_SEL_W-1:0] dp_alu_sel,
  output logic                 dp_mux_sel,
  output logic [WIDTH-1:0]     dp_immediate,
  output logic                 is_branch,
  output logic                 is_halt,
  output logic                 updates_carry
);

  logic [1:0] instr_type;
  logic       unused_ign_bit;

  assign instr_type     = ir[TYPE_MSB:TYPE_LSB];
  // Bit 8 carries no meaning in any instruction format.
  assign unused_ign_bit = ir[IGN_BIT];

  always_comb begin
    dp_write_en   = 1'b0;
    dp_write_addr = '0;
    dp_read_addr1 = '0;
    dp_read_addr2 = '0;
    dp_alu_sel    = '0;
    dp_mux_sel    = 1'b0;
    dp_immediate  = '0;
    is_branch     = 1'b0;
    is_halt       = 1'b0;
    updates_carry = 1'b0;
    if (exec_valid) begin
      case (instr_type)
        TYPE_ALU_R, TYPE_ALU_I: begin
          dp_write_en   = 1'b1;
          dp_write_addr = ir[RD_LSB +: RA_W];
          dp_read_addr1 = ir[RS1_LSB +: RA_W];
          dp_read_addr2 = ir[RS2_LSB +: RA_W];
          dp_alu_sel    = ir[ALU_MSB:ALU_LSB];
          updates_carry = 1'b1;
          if (instr_type == TYPE_ALU_I) begin
            dp_mux_sel   = 1'b1;
            dp_immediate = ir[IMM_LSB +: WIDTH];
          end
        end
        TYPE_BRC:  is_branch = 1'b1;
        TYPE_HALT: is_halt   = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer driving the register-file + ALU
// datapath from a synchronous instruction memory.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; busy=0
// ST_FETCH | imem_en=1, imem_addr=pc
// ST_WAIT  | memory returns the word; ir is loaded at the end of this cycle
// ST_EXEC  | datapath controls decoded from ir; pc/carry updated; 1 cycle
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start               begin execution at address 0 (only seen in IDLE)
//   imem_en/addr/data   instruction memory read port, 1-cycle latency
//   dp_*                datapath controls, 0 outside EXEC
//   dp_carry_out        ALU carry of the executing operation
//   busy, done          host handshake; done pulses in the HALT EXEC cycle
module cpu_seq_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int REG_COUNT = 8,
  parameter  int PC_W      = 8,
  parameter  int INSTR_W   = 20,
  localparam int RA_W      = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 imem_en,
  output logic [PC_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]   imem_data,
  output logic                 dp_write_en,
  output logic [RA_W-1:0]      dp_write_addr,
  output logic [RA_W-1:0]      dp_read_addr1,
  output logic [RA_W-1:0]      dp_read_addr2,
  output logic [ALU_SEL_W-1:0] dp_alu_sel,
  output logic                 dp_mux_sel,
  output logic [WIDTH-1:0]     dp_immediate,
  input  logic                 dp_carry_out,
  output logic                 busy,
  output logic                 done
);

  state_t             state;
  state_t             state_nx;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic               carry_flag;

  logic               dec_write_en;
  logic               is_branch;
  logic               is_halt;
  logic               updates_carry;

  cpu_instr_decode #(
    .WIDTH   (WIDTH),
    .RA_W    (RA_W),
    .INSTR_W (INSTR_W)
  ) u_decode (
    .ir            (ir),
    .exec_valid    (state == ST_EXEC),
    .dp_write_en   (dec_write_en),
    .dp_write_addr (dp_write_addr),
    .dp_read_addr1 (dp_read_addr1),
    .dp_read_addr2 (dp_read_addr2),
    .dp_alu_sel    (dp_alu_sel),
    .dp_mux_sel    (dp_mux_sel),
    .dp_immediate  (dp_immediate),
    .is_branch     (is_branch),
    .is_halt       (is_halt),
    .updates_carry (updates_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_FETCH;
      ST_FETCH: state_nx = ST_WAIT;
      ST_WAIT:  state_nx = ST_EXEC;
      ST_EXEC:  state_nx = is_halt ? ST_IDLE : ST_FETCH;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // pc is held across HALT so the host can see where the program stopped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      ir         <= '0;
      carry_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pc         <= '0;
            carry_flag <= 1'b0;
          end
        end
        ST_WAIT: ir <= imem_data;
        ST_EXEC: begin
          if (updates_carry) carry_flag <= dp_carry_out;
          if (is_branch && carry_flag) pc <= ir[IMM_LSB +: PC_W];
          else if (!is_halt)           pc <= pc + PC_W'(1);
        end
        default: ;
      endcase
    end
  end

  // A reset landing on an EXEC cycle must not let the register write commit.
  always_comb begin
    imem_en     = (state == ST_FETCH);
    busy        = (state != ST_IDLE);
    dp_write_en = dec_write_en & ~rst;
    done        = is_halt & ~rst;
  end

  assign imem_addr = pc;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
module tb_cpu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [19:0] imem_data;
  logic        dp_write_en;
  logic [2:0]  dp_write_addr;
  logic [2:0]  dp_read_addr1;
  logic [2:0]  dp_read_addr2;
  logic [2:0]  dp_alu_sel;
  logic        dp_mux_sel;
  logic [7:0]  dp_immediate;
  logic        dp_carry_out;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [19:0] rom [256];

  cpu_seq_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .dp_write_en   (dp_write_en),
    .dp_write_addr (dp_write_addr),
    .dp_read_addr1 (dp_read_addr1),
    .dp_read_addr2 (dp_read_addr2),
    .dp_alu_sel    (dp_alu_sel),
    .dp_mux_sel    (dp_mux_sel),
    .dp_immediate  (dp_immediate),
    .dp_carry_out  (dp_carry_out),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Synchronous instruction ROM: word appears the cycle after imem_en.
  always @(posedge clk) begin
    if (imem_en) imem_data <= rom[imem_addr];
  end

  localparam logic [19:0] HALT_I = 20'hC0000;

  function automatic logic [19:0] mk(input logic [1:0] t, input logic [2:0] alu,
                                     input logic [2:0] rd, input logic [2:0] rs1,
                                     input logic [7:0] imm);
    return {t, alu, rd, rs1, 1'b0, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dp_bus();
    return 32'({dp_write_en, dp_write_addr, dp_read_addr1, dp_read_addr2,
                dp_alu_sel, dp_mux_sel, dp_immediate});
  endfunction

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = HALT_I;
  endtask

  task automatic go_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    check(nm, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [19:0] instr;
    logic        pre_c;
    logic        we;
    logic [2:0]  wa;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic [2:0]  alu;
    logic        mux;
    logic [7:0]  imm;
    logic        dn;
    logic [7:0]  nxt;
  } vec_t;

  vec_t vecs [8];

  // Behavioural ISA-level model state for the random programs.
  logic [7:0]  m_pc;
  logic        m_c;

  initial begin
    logic [19:0] setter;
    logic [19:0] ins;
    logic [1:0]  t;
    logic        is_alu;
    logic        cin;
    logic        halted;

    rst = 1'b1; start = 1'b0; dp_carry_out = 1'b0;
    rom_clear();
    setter = mk(2'b01, 3'd0, 3'd0, 3'd0, 8'h00);

    vecs[0] = '{mk(2'b01,3'd0,3'd1,3'd0,8'h05), 1'b0, 1'b1, 3'd1, 3'd0, 3'd5, 3'd0, 1'b1, 8'h05, 1'b0, 8'h02};
    vecs[1] = '{mk(2'b00,3'd2,3'd3,3'd1,8'h02), 1'b0, 1'b1, 3'd3, 3'd1, 3'd2, 3'd2, 1'b0, 8'h00, 1'b0, 8'h02};
    vecs[2] = '{mk(2'b10,3'd0,3'd0,3'd0,8'h10), 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h10};
    vecs[3] = '{mk(2'b10,3'd0,3'd0,3'd0,8'h10), 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h02};
    vecs[4] = '{HALT_I,                          1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[5] = '{{2'b00,3'd7,3'd7,3'd7,1'b1,8'hFF}, 1'b1, 1'b1, 3'd7, 3'd7, 3'd7, 3'd7, 1'b0, 8'h00, 1'b0, 8'h02};
    vecs[6] = '{{2'b10,3'd5,3'd6,3'd3,1'b1,8'hA5}, 1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 8'hA5};
    vecs[7] = '{mk(2'b01,3'd6,3'd0,3'd4,8'hF0), 1'b0, 1'b1, 3'd0, 3'd4, 3'd0, 3'd6, 1'b1, 8'hF0, 1'b0, 8'h02};

    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_imem_en", 32'(imem_en), 0);
    check("rst_imem_addr", 32'(imem_addr), 0);
    check("rst_dp", dp_bus(), 0);
    check("rst_done", 32'(done), 0);

    // Two-instruction program: busy over cycles 1..6, done at cycle 6 only.
    rom_clear();
    rom[0] = mk(2'b01, 3'd0, 3'd1, 3'd0, 8'h05);
    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      start = 1'b0;
      check($sformatf("seq_busy_c%0d", c), 32'(busy), 32'(c <= 6));
      check($sformatf("seq_done_c%0d", c), 32'(done), 32'(c == 6));
      check($sformatf("seq_imem_en_c%0d", c), 32'(imem_en), 32'(c == 1 || c == 4));
      if (c == 1 || c == 2 || c == 4 || c == 5)
        check($sformatf("seq_dp_zero_c%0d", c), dp_bus(), 0);
      if (c == 3) begin
        check("seq_we", 32'(dp_write_en), 1);
        check("seq_wa", 32'(dp_write_addr), 1);
        check("seq_mux", 32'(dp_mux_sel), 1);
        check("seq_imm", 32'(dp_immediate), 32'h05);
      end
    end

    // Table vectors: a carry-setting op at 0, the vector instruction at 1.
    for (int v = 0; v < 8; v++) begin
      rom_clear();
      rom[0] = setter;
      rom[1] = vecs[v].instr;
      go_start();
      tick(); tick();
      dp_carry_out = vecs[v].pre_c;
      tick();
      dp_carry_out = 1'b0;
      check($sformatf("v%0d_fetch_addr", v), 32'(imem_addr), 1);
      tick();
      check($sformatf("v%0d_wait_dp", v), dp_bus(), 0);
      tick();
      check($sformatf("v%0d_we", v),   32'(dp_write_en),   32'(vecs[v].we));
      check($sformatf("v%0d_wa", v),   32'(dp_write_addr), 32'(vecs[v].wa));
      check($sformatf("v%0d_ra1", v),  32'(dp_read_addr1), 32'(vecs[v].ra1));
      check($sformatf("v%0d_ra2", v),  32'(dp_read_addr2), 32'(vecs[v].ra2));
      check($sformatf("v%0d_alu", v),  32'(dp_alu_sel),    32'(vecs[v].alu));
      check($sformatf("v%0d_mux", v),  32'(dp_mux_sel),    32'(vecs[v].mux));
      check($sformatf("v%0d_imm", v),  32'(dp_immediate),  32'(vecs[v].imm));
      check($sformatf("v%0d_done", v), 32'(done),          32'(vecs[v].dn));
      tick();
      if (vecs[v].dn) begin
        check($sformatf("v%0d_idle", v), 32'(busy), 0);
        check($sformatf("v%0d_pc_held", v), 32'(imem_addr), 1);
      end else begin
        check($sformatf("v%0d_next_addr", v), 32'(imem_addr), 32'(vecs[v].nxt));
        wait_idle($sformatf("v%0d_halt_timeout", v), 20);
      end
    end

    // Restart after HALT must clear the carry flag.
    rom_clear();
    rom[0] = mk(2'b10, 3'd0, 3'd0, 3'd0, 8'h20);
    rom[1] = setter;
    go_start();
    tick(); tick(); tick();
    check("rs_nobranch", 32'(imem_addr), 1);
    tick(); tick();
    dp_carry_out = 1'b1;
    tick();
    dp_carry_out = 1'b0;
    tick(); tick();
    check("rs_halt_done", 32'(done), 1);
    tick();
    check("rs_idle", 32'(busy), 0);
    go_start();
    check("rs_fetch0", 32'(imem_addr), 0);
    tick(); tick(); tick();
    check("rs_carry_clear", 32'(imem_addr), 1);
    wait_idle("rs_timeout", 20);

    // Branch to 0xFF, wrap to 0x00, then reset during the EXEC at 0xFF.
    rom_clear();
    rom[0] = setter;
    rom[1] = mk(2'b10, 3'd0, 3'd0, 3'd0, 8'hFF);
    rom[8'hFF] = mk(2'b00, 3'd0, 3'd2, 3'd2, 8'h02);
    go_start();
    for (int lap = 0; lap < 2; lap++) begin
      tick(); tick();
      dp_carry_out = 1'b1;
      tick();
      dp_carry_out = 1'b0;
      tick(); tick(); tick();
      check($sformatf("wrap_target_l%0d", lap), 32'(imem_addr), 32'hFF);
      tick(); tick();
      if (lap == 0) begin
        tick();
        check("pc_wrap", 32'(imem_addr), 0);
        check("pc_wrap_en", 32'(imem_en), 1);
      end
    end
    check("rst_pre_we", 32'(dp_write_en), 1);
    rst = 1'b1;
    #1;
    check("rst_we_gate", 32'(dp_write_en), 0);
    check("rst_no_done", 32'(done), 0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_pc", 32'(imem_addr), 0);
    check("rst_mid_en", 32'(imem_en), 0);
    check("rst_mid_done", 32'(done), 0);

    // Random programs against the instruction-level model; start toggles
    // freely while busy and must have no effect.
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < 256; i++) begin
        logic [31:0] r;
        r = $urandom;
        if (r[31:29] == 3'd0) rom[i] = HALT_I;
        else rom[i] = {2'(r[28:27] % 3), r[17:0]};
      end
      m_pc = 8'd0;
      m_c = 1'b0;
      halted = 1'b0;
      go_start();
      for (int k = 0; k < 60 && !halted; k++) begin
        check("r_fetch_en", 32'(imem_en), 1);
        check("r_fetch_addr", 32'(imem_addr), 32'(m_pc));
        check("r_fetch_dp", dp_bus(), 0);
        start = 1'($urandom);
        tick();
        check("r_wait_busy", 32'(busy), 1);
        check("r_wait_dp", 32'({imem_en, dp_bus()}), 0);
        start = 1'($urandom);
        tick();
        ins = rom[m_pc];
        t = ins[19:18];
        is_alu = (t == 2'b00) || (t == 2'b01);
        cin = 1'($urandom);
        dp_carry_out = cin;
        check("r_we",  32'(dp_write_en),   32'(is_alu));
        check("r_wa",  32'(dp_write_addr), is_alu ? 32'(ins[14:12]) : 0);
        check("r_ra1", 32'(dp_read_addr1), is_alu ? 32'(ins[11:9]) : 0);
        check("r_ra2", 32'(dp_read_addr2), is_alu ? 32'(ins[2:0]) : 0);
        check("r_alu", 32'(dp_alu_sel),    is_alu ? 32'(ins[17:15]) : 0);
        check("r_mux", 32'(dp_mux_sel),    32'(t == 2'b01));
        check("r_imm", 32'(dp_immediate),  (t == 2'b01) ? 32'(ins[7:0]) : 0);
        check("r_done", 32'(done),         32'(t == 2'b11));
        start = 1'($urandom);
        tick();
        start = 1'b0;
        if (is_alu) begin
          m_c = cin;
          m_pc = m_pc + 8'd1;
        end else if (t == 2'b10) begin
          m_pc = m_c ? ins[7:0] : m_pc + 8'd1;
        end else begin
          halted = 1'b1;
          check("r_halt_idle", 32'(busy), 0);
          check("r_halt_pc", 32'(imem_addr), 32'(m_pc));
        end
      end
      dp_carry_out = 1'b0;
      if (!halted) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("r_rst_idle", 32'(busy), 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
